dcim_serial_mac: RTL

Parametrised bit-serial successor to the DCIM local MAC: holds a ROWS×LANES weight tile and accepts input activations one bit-plane per beat, LSB first. Each beat it forms the row/lane partial sum and shift-accumulates it into a signed result. Weights and inputs are each independently signed or unsigned. Sits between the macro's input bit-plane driver and the column-group adder, with a start/valid/ready handshake to both.

---
 rtl/dcim_pkg.sv | 30 +++
 rtl/local_psum_tree.sv | 40 ++++
 rtl/dcim_serial_mac.sv | 102 ++++++++++
 3 files changed

// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM bit-serial MAC blocks.
// Holds the MAC state encoding, default tile geometry and the width helpers
// that derive partial-sum and accumulator widths from that geometry.
package dcim_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int DEF_ROWS    = 2;
  localparam int DEF_LANES   = 8;
  localparam int DEF_W_BITS  = 4;
  localparam int DEF_IN_BITS = 8;

  // Signed partial-sum width: one weight word, growth for ROWS*LANES terms,
  // plus a sign bit so unsigned weights still fit a signed container.
  function automatic int psum_w(input int rows, input int lanes, input int w_bits);
    return w_bits + $clog2(rows * lanes) + 1;
  endfunction

  // Accumulator width: partial sum scaled by up to 2^(IN_BITS-1) in either
  // direction; one extra bit per activation bit covers both sign modes.
  function automatic int acc_w(input int rows, input int lanes, input int w_bits,
                               input int in_bits);
    return psum_w(rows, lanes, w_bits) + in_bits;
  endfunction

endpackage

// File: rtl/local_psum_tree.sv
// Combinational bit-plane partial sum for one weight tile.
// Each word contributes its weight (sign- or zero-extended) when its
// activation bit is set; the contributions are summed into psum.
//   in_bits  : one activation bit per word, word i at bit i
//   wt       : weights, word i at [i*W_BITS +: W_BITS]
//   w_signed : 1 = weights are two's complement
//   psum     : signed sum of gated weights
module local_psum_tree
  import dcim_pkg::*;
#(
  parameter  int ROWS   = DEF_ROWS,
  parameter  int LANES  = DEF_LANES,
  parameter  int W_BITS = DEF_W_BITS,
  localparam int N      = ROWS * LANES,
  localparam int PSUM_W = psum_w(ROWS, LANES, W_BITS)
) (
  input  logic [N-1:0]              in_bits,
  input  logic [N*W_BITS-1:0]       wt,
  input  logic                      w_signed,
  output logic signed [PSUM_W-1:0]  psum
);

  logic [N-1:0][PSUM_W-1:0] term;

  for (genvar i = 0; i < N; i++) begin : g_word
    logic [W_BITS-1:0] w;
    logic              ext;
    assign w       = wt[i*W_BITS +: W_BITS];
    assign ext     = w_signed & w[W_BITS-1];
    assign term[i] = in_bits[i] ? {{(PSUM_W-W_BITS){ext}}, w} : '0;
  end

  // PSUM_W is sized so the exact sum never overflows; plain modular adds
  // are therefore exact. Synthesis balances this chain into a tree.
  always_comb begin
    psum = '0;
    for (int i = 0; i < N; i++) psum = psum + $signed(term[i]);
  end

endmodule

// File: rtl/dcim_serial_mac.sv
// Bit-serial MAC over a ROWS x LANES weight tile.
// Activations arrive one bit-plane per beat, LSB first; each beat's partial
// sum is shifted by the beat index and accumulated. With signed activations
// the MSB plane carries negative weight and is subtracted.
//   start/w_signed/x_signed : launch an operation, latch sign modes
//   wt                      : weight tile, stable for the whole operation
//   in_valid/in_bits/in_ready : bit-plane beat handshake
//   busy                    : operation in progress
//   out_valid/out_ready/result : signed result handshake
module dcim_serial_mac
  import dcim_pkg::*;
#(
  parameter  int ROWS    = DEF_ROWS,
  parameter  int LANES   = DEF_LANES,
  parameter  int W_BITS  = DEF_W_BITS,
  parameter  int IN_BITS = DEF_IN_BITS,
  localparam int PSUM_W  = psum_w(ROWS, LANES, W_BITS),
  localparam int ACC_W   = acc_w(ROWS, LANES, W_BITS, IN_BITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        w_signed,
  input  logic                        x_signed,
  input  logic [ROWS*LANES*W_BITS-1:0] wt,
  input  logic                        in_valid,
  input  logic [ROWS*LANES-1:0]       in_bits,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            result
);

  localparam int BEAT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_BITS - 1);

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     w_sgn_q, x_sgn_q;
  logic signed [PSUM_W-1:0] psum;
  logic signed [ACC_W-1:0]  term;
  logic                     fire, last, launch;

  local_psum_tree #(
    .ROWS   (ROWS),
    .LANES  (LANES),
    .W_BITS (W_BITS)
  ) u_tree (
    .in_bits  (in_bits),
    .wt       (wt),
    .w_signed (w_sgn_q),
    .psum     (psum)
  );

  assign fire   = (state_q == S_ACCUM) && in_valid;
  assign last   = (beat_q == LAST_BEAT);
  // HOLD with out_ready and start hands straight over to a fresh operation.
  assign launch = start && ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));

  // Sign-extend psum to accumulator width, then weight by 2^beat.
  assign term = {{IN_BITS{psum[PSUM_W-1]}}, psum} <<< beat_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (fire && last) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = start ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      beat_q  <= '0;
      w_sgn_q <= 1'b0;
      x_sgn_q <= 1'b0;
    end else if (launch) begin
      acc_q   <= '0;
      beat_q  <= '0;
      w_sgn_q <= w_signed;
      x_sgn_q <= x_signed;
    end else if (fire) begin
      acc_q  <= (last && x_sgn_q) ? acc_q - term : acc_q + term;
      beat_q <= beat_q + 1'b1;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = acc_q;

endmodule
